instr_decode_fifo: RTL



---
 rtl/instr_decode_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/instr_decode_fifo.sv
// Instruction decoder with a DEPTH-entry FIFO. Words are split into A/C-instruction
// fields when they are pushed. The head entry is presented over a valid/ready port.
module instr_decode_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DW-1:0]              in_instr,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              instr_v,
    output logic                       instr_type,
    output logic                       cmd_a,
    output logic [5:0]                 cmd_c,
    output logic [2:0]                 cmd_d,
    output logic [2:0]                 cmd_j,
    output logic                       illegal,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [CNTW-1:0]            illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    // Entry layout: {illegal, instr[12:0] (a,c,d,j), type, raw word}
    localparam int EW = DW + 15;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // valid must not depend on ready. in_ready and out_valid come only from the fill register.
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          dec_type;
    logic          dec_ill;
    logic [EW-1:0] dec_entry;
    logic [EW-1:0] head;

    assign in_ready  = (fill < FW'(DEPTH));
    assign out_valid = (fill != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign dec_type  = in_instr[DW-1];
    assign dec_ill   = dec_type && !(&in_instr[DW-2:13]);
    assign dec_entry = dec_type ? {dec_ill, in_instr[12:0], 1'b1, in_instr}
                                : {15'b0, in_instr};

    // An empty FIFO presents all-zero head fields, whatever the storage holds.
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign instr_v    = head[DW-1:0];
    assign instr_type = head[DW];
    assign cmd_j      = head[DW+3:DW+1];
    assign cmd_d      = head[DW+6:DW+4];
    assign cmd_c      = head[DW+12:DW+7];
    assign cmd_a      = head[DW+13];
    assign illegal    = head[DW+14];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fill <= fill + FW'(1);
            end else if (pop && !push) begin
                fill <= fill - FW'(1);
            end
            if (push && dec_ill && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNTW'(1);
            end
        end
    end
endmodule
